// File: rtl/batch_dispatcher.sv
// Ping-pong batch collector and round-robin lane dispatcher.
// Optional timeout sealing: define BATCH_DISPATCH_TIMEOUT_EN.
module batch_dispatcher #(
  parameter int MAX_BATCH_SIZE = 48,
  parameter int INDEX_BITS     = 6,
  parameter int NUM_LANES      = 4,
  parameter int LANE_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_BITS   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [63:0]           in_id,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [NUM_LANES-1:0]  lane_idle,
  output logic [NUM_LANES-1:0]  lane_start,
  output logic                  out_valid,
  output logic [63:0]           out_id,
  output logic [LANE_BITS-1:0]  out_lane,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  batch_sealed,
  output logic [INDEX_BITS-1:0] sealed_size,
  output logic                  batch_clear,
  output logic [31:0]           batches_dispatched
);

  typedef enum logic {
    D_IDLE,
    D_STREAM
  } d_state_t;

  localparam logic [INDEX_BITS-1:0] MAX_CNT =
    INDEX_BITS'(MAX_BATCH_SIZE);

  logic [63:0]           bank [2][MAX_BATCH_SIZE];
  logic [1:0]            sealed;
  logic [INDEX_BITS-1:0] count [2];
  logic                  fill_sel;
  logic                  disp_sel;
  d_state_t              state;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [LANE_BITS-1:0]  last_lane;
  logic [LANE_BITS-1:0]  grant_lane;
  logic [LANE_BITS-1:0]  rr;
  logic                  grant_ok;
  logic                  accept;
  logic                  seal;
  logic                  timeout_hit;
  logic [INDEX_BITS-1:0] cnt_fill;
  logic [INDEX_BITS-1:0] cnt_next;
  logic [INDEX_BITS-1:0] disp_cnt;

  assign in_ready = !sealed[fill_sel];
  assign accept   = in_valid && in_ready;
  assign cnt_fill = count[fill_sel];
  assign cnt_next = cnt_fill + INDEX_BITS'(accept);
  assign disp_cnt = count[disp_sel];

  assign seal = !sealed[fill_sel] &&
                (cnt_next == MAX_CNT ||
                 (flush && cnt_next != '0) ||
                 timeout_hit);

  assign out_valid = (state == D_STREAM);
  assign out_last  = out_valid &&
                     (rd_idx == disp_cnt - INDEX_BITS'(1));
  assign out_id    = out_valid ? bank[disp_sel][rd_idx] : '0;

`ifdef BATCH_DISPATCH_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] timer;

  // Next value reaching TIMEOUT_CYCLES-1 seals on this edge.
  assign timeout_hit = (cnt_fill != '0) &&
    (timer == TIMEOUT_BITS'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (seal || cnt_fill == '0 || sealed[fill_sel]) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMEOUT_BITS'(1);
    end
  end
`else
  logic [TIMEOUT_BITS-1:0] unused_timeout;

  assign unused_timeout = TIMEOUT_BITS'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // Scan from farthest to nearest so the lane right after last_lane wins.
  always_comb begin
    grant_ok   = 1'b0;
    grant_lane = '0;
    rr         = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      rr = LANE_BITS'((int'(last_lane) + k) % NUM_LANES);
      if (lane_idle[rr]) begin
        grant_ok   = 1'b1;
        grant_lane = rr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bank[fill_sel][cnt_fill] <= in_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sealed             <= '0;
      count[0]           <= '0;
      count[1]           <= '0;
      fill_sel           <= 1'b0;
      disp_sel           <= 1'b0;
      state              <= D_IDLE;
      rd_idx             <= '0;
      out_lane           <= '0;
      last_lane          <= LANE_BITS'(NUM_LANES - 1);
      lane_start         <= '0;
      batch_sealed       <= 1'b0;
      batch_clear        <= 1'b0;
      sealed_size        <= '0;
      batches_dispatched <= '0;
    end else begin
      lane_start   <= '0;
      batch_sealed <= seal;
      batch_clear  <= seal;
      if (accept) begin
        count[fill_sel] <= cnt_next;
      end
      if (seal) begin
        sealed[fill_sel] <= 1'b1;
        sealed_size      <= cnt_next;
        fill_sel         <= !fill_sel;
      end
      unique case (state)
        D_IDLE: begin
          if (sealed[disp_sel] && grant_ok) begin
            lane_start <= NUM_LANES'(1) << grant_lane;
            out_lane   <= grant_lane;
            rd_idx     <= '0;
            state      <= D_STREAM;
          end
        end
        D_STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              sealed[disp_sel]   <= 1'b0;
              count[disp_sel]    <= '0;
              disp_sel           <= !disp_sel;
              last_lane          <= out_lane;
              batches_dispatched <= batches_dispatched + 32'd1;
              state              <= D_IDLE;
            end else begin
              rd_idx <= rd_idx + INDEX_BITS'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batch_dispatcher.sv
// Self-checking bench for batch_dispatcher against a queue-based model.
// Honours BATCH_DISPATCH_TIMEOUT_EN the same way the design does.
module tb_batch_dispatcher;

  localparam int MB = 48;
  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_id = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [3:0]  lane_idle = '0;
  logic [3:0]  lane_start;
  logic        out_valid;
  logic [63:0] out_id;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        batch_sealed;
  logic [5:0]  sealed_size;
  logic        batch_clear;
  logic [31:0] batches_dispatched;

  batch_dispatcher #(
    .MAX_BATCH_SIZE(48),
    .INDEX_BITS(6),
    .NUM_LANES(4),
    .LANE_BITS(2),
    .TIMEOUT_CYCLES(256),
    .TIMEOUT_BITS(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_id(in_id),
    .in_ready(in_ready),
    .flush(flush),
    .lane_idle(lane_idle),
    .lane_start(lane_start),
    .out_valid(out_valid),
    .out_id(out_id),
    .out_lane(out_lane),
    .out_last(out_last),
    .out_ready(out_ready),
    .batch_sealed(batch_sealed),
    .sealed_size(sealed_size),
    .batch_clear(batch_clear),
    .batches_dispatched(batches_dispatched)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the batch being filled, up to two sealed batches (b0 oldest).
  logic [63:0] fillq[$];
  logic [63:0] b0[$];
  logic [63:0] b1[$];
  int          ns;
  bit          strm;
  int          idx;
  int          lane;
  int          last_lane;
  int          disp;
  int          first_edge;
  int          edge_no;
  int          exp_ls;
  bit          exp_seal;
  int          exp_size;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    fillq.delete();
    b0.delete();
    b1.delete();
    ns = 0;
    strm = 0;
    idx = 0;
    lane = 0;
    last_lane = NL - 1;
    disp = 0;
    first_edge = 0;
    exp_ls = 0;
    exp_seal = 0;
    exp_size = 0;
  endtask

  task automatic model_step();
    bit rdy;
    bit acc;
    bit fr;
    bit to;
    bit sl;
    int n;
    int ns_pre;
    edge_no++;
    rdy = (ns < 2);
    acc = in_valid && rdy;
    fr = strm && out_ready && (idx == b0.size() - 1);
    n = fillq.size() + int'(acc);
    to = 0;
`ifdef BATCH_DISPATCH_TIMEOUT_EN
    to = (fillq.size() > 0) && (edge_no - first_edge == 255);
`endif
    sl = rdy && (n == MB || (flush && n > 0) || to);
    ns_pre = ns;
    if (acc) begin
      if (fillq.size() == 0) first_edge = edge_no;
      fillq.push_back(in_id);
    end
    exp_ls = 0;
    if (fr) begin
      b0 = b1;
      b1.delete();
      ns--;
      strm = 0;
      last_lane = lane;
      disp++;
    end else if (strm) begin
      if (out_ready) idx++;
    end else if (ns_pre > 0 && lane_idle != 0) begin
      for (int k = NL; k >= 1; k--) begin
        if (lane_idle[(last_lane + k) % NL]) lane = (last_lane + k) % NL;
      end
      strm = 1;
      idx = 0;
      exp_ls = 1 << lane;
    end
    if (sl) begin
      if (ns == 0) b0 = fillq;
      else b1 = fillq;
      ns++;
      exp_size = n;
      fillq.delete();
    end
    exp_seal = sl;
  endtask

  task automatic compare();
    chk("in_ready", 64'(in_ready), 64'(ns < 2));
    chk("lane_start", 64'(lane_start), 64'(exp_ls));
    chk("out_valid", 64'(out_valid), 64'(strm));
    if (strm) begin
      chk("out_id", out_id, b0[idx]);
      chk("out_lane", 64'(out_lane), 64'(lane));
      chk("out_last", 64'(out_last), 64'(idx == b0.size() - 1));
    end else begin
      chk("out_id_idle", out_id, 64'(0));
      chk("out_last_idle", 64'(out_last), 64'(0));
    end
    chk("batch_sealed", 64'(batch_sealed), 64'(exp_seal));
    chk("batch_clear", 64'(batch_clear), 64'(exp_seal));
    chk("sealed_size", 64'(sealed_size), 64'(exp_size));
    chk("dispatched", 64'(batches_dispatched), 64'(disp));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  int seal_at;
  int exp_at;

  initial begin
    edge_no = 0;
    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_id", out_id, 64'(0));
    chk("rst_lane_start", 64'(lane_start), 64'(0));
    chk("rst_sealed_size", 64'(sealed_size), 64'(0));
    chk("rst_sealed", 64'(batch_sealed), 64'(0));
    chk("rst_dispatched", 64'(batches_dispatched), 64'(0));

    // Full batch of 1..48
    lane_idle = 4'hF;
    out_ready = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      in_valid = 1'b1;
      in_id = 64'(k);
      cycle();
    end
    chk("t1_sealed", 64'(batch_sealed), 64'(1));
    chk("t1_size", 64'(sealed_size), 64'(48));
    in_valid = 1'b0;
    cycle();
    chk("t1_grant", 64'(lane_start), 64'(4'b0001));
    chk("t1_first_id", out_id, 64'(1));
    repeat (47) cycle();
    chk("t1_last_id", out_id, 64'(48));
    chk("t1_last", 64'(out_last), 64'(1));
    cycle();
    chk("t1_dispatched", 64'(batches_dispatched), 64'(1));

    // Partial batch sealed by flush, then flush on empty bank
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_id = 64'(101 + k);
      cycle();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    chk("t2_size", 64'(sealed_size), 64'(5));
    chk("t2_clear", 64'(batch_clear), 64'(1));
    cycle();
    chk("t2_empty_flush", 64'(batch_sealed), 64'(0));
    chk("t2_grant", 64'(lane_start), 64'(4'b0010));
    flush = 1'b0;
    repeat (8) cycle();
    chk("t2_dispatched", 64'(batches_dispatched), 64'(2));

    // Timeout: 3 IDs then idle
    in_valid = 1'b1;
    in_id = 64'd201;
    cycle();
    seal_at = -1;
    for (int i = 1; i <= 300; i++) begin
      in_valid = (i <= 2);
      in_id = 64'(201 + i);
      cycle();
      if (batch_sealed && seal_at < 0) seal_at = i;
    end
    in_valid = 1'b0;
`ifdef BATCH_DISPATCH_TIMEOUT_EN
    exp_at = 255;
`else
    exp_at = -1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
`endif
    chk("t3_timeout", 64'(seal_at), 64'(exp_at));
    repeat (10) cycle();

    // Back-pressure: no idle lanes, both banks fill
    lane_idle = 4'h0;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1;
      in_id = 64'(1000 + k);
      cycle();
    end
    in_valid = 1'b0;
    chk("t4_full", 64'(in_ready), 64'(0));
    lane_idle = 4'b0100;
    cycle();
    chk("t4_grant", 64'(lane_start), 64'(4'b0100));
    repeat (47) cycle();
    chk("t4_still_full", 64'(in_ready), 64'(0));
    cycle();
    chk("t4_freed", 64'(in_ready), 64'(1));
    repeat (55) cycle();

    // Round-robin order from reset
    do_reset();
    lane_idle = 4'hF;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_id = 64'(500 + 2 * b);
      cycle();
      in_id = 64'(501 + 2 * b);
      flush = 1'b1;
      cycle();
      in_valid = 1'b0;
      flush = 1'b0;
      cycle();
      chk("t5_rr", 64'(lane_start), 64'(1 << (b % 4)));
      repeat (3) cycle();
    end

    // Random traffic with stalls
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_id = {$urandom(), $urandom()};
      flush = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      lane_idle = 4'($urandom_range(0, 15));
      cycle();
    end
    in_valid = 1'b0;
    lane_idle = 4'hF;
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (200) cycle();

    // Reset in the middle of a stream
    for (int k = 1; k <= 48; k++) begin
      in_valid = 1'b1;
      in_id = 64'(7000 + k);
      cycle();
    end
    in_valid = 1'b0;
    repeat (10) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_out_valid", 64'(out_valid), 64'(0));
    chk("t7_out_id", out_id, 64'(0));
    chk("t7_out_lane", 64'(out_lane), 64'(0));
    chk("t7_out_last", 64'(out_last), 64'(0));
    chk("t7_in_ready", 64'(in_ready), 64'(1));
    chk("t7_size", 64'(sealed_size), 64'(0));
    chk("t7_dispatched", 64'(batches_dispatched), 64'(0));
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("t7_no_beat", 64'(out_valid), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
